// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops bytes and sends start, 8 data bits LSB first, optional even parity, stop.
// Defining FIFO_UART_TX_PARITY_EN inserts the parity bit, giving 11-bit frames instead of 10.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_q,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             txd_reg, txd_next;
  logic             done_reg, done_next;
  logic             bit_end;

`ifdef FIFO_UART_TX_PARITY_EN
  logic       par_reg, par_next;
  logic [8:0] par_chain;

  // Even parity of the head byte, latched together with the byte at pop time.
  assign par_chain[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ fifo_q[gi];
    end
  endgenerate
`endif

  assign bit_end = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    fifo_rd    = 1'b0;
    txd_next   = 1'b1;
    done_next  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_next   = par_reg;
`endif

    if (state_reg != IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (!fifo_empty && rst) begin
          fifo_rd    = 1'b1;
          shift_next = fifo_q;
          bit_next   = 3'd0;
          cnt_next   = '0;
          state_next = START;
`ifdef FIFO_UART_TX_PARITY_EN
          par_next   = par_chain[8];
`endif
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_reg == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            shift_next = shift_reg >> 1;
            bit_next   = bit_reg + 3'd1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // txd is registered, so it is decoded from the state being entered.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  txd_next = par_next;
`endif
      default: txd_next = 1'b1;
    endcase

    done_next = (state_next == STOP) && (cnt_next == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'd0;
      txd_reg   <= 1'b1;
      done_reg  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
      done_reg  <= done_next;
`ifdef FIFO_UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  assign txd     = txd_reg;
  assign busy    = (state_reg != IDLE);
  assign tx_done = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, per-cycle reference model with a byte scoreboard, table of frames.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] fifo_q;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       txd;
  logic       busy;
  logic       tx_done;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .txd(txd), .busy(busy), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fr_idx = -1;
  int frames_done = 0;
  int busy_cnt = 0;
  logic chk_en = 1'b0;
  logic gate = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  logic [10:0] rx_vec = '0;
  logic [10:0] last_frame = '0;
  logic [7:0] fq[$];
  logic [7:0] sb_q[$];
  int rd_cycles[$];
  int done_cycles[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    fifo_empty = gate || (fq.size() == 0);
    fifo_q = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    refresh();
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (j == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    logic rd_s, exp_rd, exp_txd, exp_busy, exp_done;
    @(negedge clk);
    if (fr_idx == 0) begin
      cur_byte = sb_q.pop_front();
      rx_vec = '0;
    end
    exp_busy = (fr_idx >= 0);
    exp_done = (fr_idx == FL * CPB - 1);
    exp_rd   = (fr_idx < 0) && !fifo_empty && rst;
    exp_txd  = (fr_idx < 0) ? 1'b1 : frame_bit(cur_byte, fr_idx / CPB);
    rd_s = fifo_rd;
    if (chk_en) begin
      check("fifo_rd", {31'd0, fifo_rd}, {31'd0, exp_rd});
      check("txd", {31'd0, txd}, {31'd0, exp_txd});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("tx_done", {31'd0, tx_done}, {31'd0, exp_done});
    end
    if (fifo_rd) rd_cycles.push_back(cyc);
    if (tx_done) done_cycles.push_back(cyc);
    if (busy) busy_cnt++;
    if (fr_idx >= 0 && (fr_idx % CPB) == CPB / 2) rx_vec[fr_idx / CPB] = txd;
    if (!rst) begin
      fr_idx = -1;
      sb_q.delete();
    end else if (exp_done) begin
      fr_idx = -1;
      last_frame = rx_vec;
      frames_done++;
      $display("frame %0d: byte=%02h line=%03h cycle=%0d", frames_done, cur_byte, rx_vec, cyc);
    end else if (fr_idx >= 0) begin
      fr_idx++;
    end else if (exp_rd) begin
      sb_q.push_back(fifo_q);
      fr_idx = 0;
    end
    @(posedge clk);
    #1;
    if (rd_s && fq.size() != 0) fq.delete(0);
    refresh();
    cyc++;
  endtask

  task automatic wait_frames(input int n, input string name);
    int target;
    target = frames_done + n;
    for (int k = 0; k < 120 * n + 50 && frames_done < target; k++) tick();
    check(name, frames_done, target);
  endtask

  initial begin
    int n0, nrd, pc;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b0};
    vecs[4] = '{8'h07, 1'b1};
    vecs[5] = '{8'h03, 1'b0};
    vecs[6] = '{8'h01, 1'b1};
    vecs[7] = '{8'h80, 1'b1};
    vecs[8] = '{8'h5A, 1'b0};

    rst = 1'b0;
    refresh();
    tick();
    rd_cycles.delete();
    done_cycles.delete();
    chk_en = 1'b1;

    // Reset held with data waiting, then released with the FIFO empty.
    push_byte(8'hA5);
    repeat (3) tick();
    gate = 1'b1;
    refresh();
    rst = 1'b1;
    repeat (5) tick();
    check("idle_no_rd", rd_cycles.size(), 0);

    // Single byte: pop count, pop-to-done latency, busy length, line pattern.
    busy_cnt = 0;
    gate = 1'b0;
    refresh();
    wait_frames(1, "a5_frame");
    check("a5_rd_count", rd_cycles.size(), 1);
    check("a5_done_count", done_cycles.size(), 1);
    if (rd_cycles.size() > 0 && done_cycles.size() > 0)
      check("a5_done_latency", done_cycles[0] - rd_cycles[0], FL * CPB);
    check("a5_busy_cycles", busy_cnt, FL * CPB);
`ifndef FIFO_UART_TX_PARITY_EN
    check("a5_line", {22'd0, last_frame[9:0]}, {22'd0, 10'b1101001010});
`endif

    // Table of single frames.
    for (int i = 0; i < 9; i++) begin
      push_byte(vecs[i].data);
      wait_frames(1, "vec_frame");
      check("vec_start", {31'd0, last_frame[0]}, 32'd0);
      check("vec_data", {24'd0, last_frame[8:1]}, {24'd0, vecs[i].data});
`ifdef FIFO_UART_TX_PARITY_EN
      check("vec_parity", {31'd0, last_frame[9]}, {31'd0, vecs[i].par});
`endif
      check("vec_stop", {31'd0, last_frame[FL-1]}, 32'd1);
    end

    // Back-to-back frames.
    rd_cycles.delete();
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(2, "b2b_frames");
    check("b2b_rd_count", rd_cycles.size(), 2);
    if (rd_cycles.size() >= 2)
      check("b2b_spacing", rd_cycles[1] - rd_cycles[0], FL * CPB + 1);
    check("b2b_last_data", {24'd0, last_frame[8:1]}, 32'hFF);

    // Reset during DATA bit 3 aborts the frame; the next byte goes out whole.
    push_byte(8'h3C);
    for (int k = 0; k < 200 && fr_idx != 17; k++) tick();
    check("mid_reach", fr_idx, 17);
    n0 = frames_done;
    push_byte(8'h81);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_txd", {31'd0, txd}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_done", {31'd0, tx_done}, 32'd0);
    wait_frames(1, "after_abort_frame");
    check("after_abort_count", frames_done, n0 + 1);
    check("after_abort_data", {24'd0, last_frame[8:1]}, 32'h81);

    // Empty stall, then resume on the first non-empty cycle.
    push_byte(8'h5A);
    wait_frames(1, "stall_frame");
    nrd = rd_cycles.size();
    repeat (20) tick();
    check("stall_no_rd", rd_cycles.size(), nrd);
    check("stall_txd", {31'd0, txd}, 32'd1);
    pc = cyc;
    push_byte(8'hC3);
    tick();
    check("resume_rd_count", rd_cycles.size(), nrd + 1);
    if (rd_cycles.size() > nrd)
      check("resume_rd_cycle", rd_cycles[rd_cycles.size()-1], pc);
    wait_frames(1, "resume_frame");
    check("resume_data", {24'd0, last_frame[8:1]}, 32'hC3);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 16x8 byte FIFO.
- Pops bytes from the FIFO's read side and serializes each one as an asynchronous serial frame on `txd`: start bit, 8 data bits LSB first, optional parity, stop bit.
- Sits between the FIFO and the board-level serial pin.
- Provides `busy` and `tx_done` status for the surrounding control logic.

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
- CNT_W, default 16: width of the bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- fifo_q  input  8  FIFO head data; combinationally valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd  output  1  FIFO pop strobe. Combinational, one cycle per byte.
- txd  output  1  serial line. Registered; idle level is 1.
- busy  output  1  high while a frame is in progress (state != IDLE). Registered-state decode.
- tx_done  output  1  one-cycle pulse in the final cycle of the stop bit. Registered.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, txd=1, tx_done=0, counters=0, shift register=0.
  - fifo_rd is forced to 0 while rst=0.
  - Reset mid-frame aborts the frame. The byte already popped is discarded and txd returns to 1 at that edge.
- States: IDLE, START, DATA, PARITY (only with PARITY_EN), STOP.
- IDLE:
  - fifo_rd = (state==IDLE) & ~fifo_empty & rst.
  - On an edge with fifo_rd=1: shift register <= fifo_q, state <= START, bit counter <= 0, txd <= 0.
  - The FIFO pops on that same edge, so capture and pop are simultaneous. There is no extra handshake latency.
- Bit timing:
  - Each serial bit is held for exactly CLKS_PER_BIT cycles.
  - The period counter counts 0..CLKS_PER_BIT-1 and restarts on every bit boundary.
- START: txd=0 for one bit period, then DATA.
- DATA:
  - txd = shift[0]; the shift register shifts right at each bit boundary.
  - The 3-bit index counts 0..7. After bit 7 go to PARITY if compiled in, else STOP.
- STOP: txd=1 for one bit period.
  - tx_done=1 during the last cycle of the stop period only.
  - Then go to IDLE.
- Back-to-back: after STOP, at least one IDLE cycle occurs (txd=1). A pop may happen in that cycle, so the minimum frame-to-frame spacing is 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity).
- fifo_empty is ignored outside IDLE. fifo_rd is never asserted outside IDLE.
- FIFO empty while in IDLE: remain in IDLE with txd=1 indefinitely.
- The counter wraps only through an explicit reload to 0. It never overflows past CLKS_PER_BIT-1.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - txd = XOR of the 8 data bits (even parity) for one bit period.
  - Frame length is 11 bit periods.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame length is 10 bit periods.

Test Plan (all with CLKS_PER_BIT=4):
- Reset and idle: hold rst=0 for 3 cycles with fifo_empty=0 -> fifo_rd=0, txd=1, busy=0, tx_done=0 throughout. Release rst with fifo_empty=1 -> stays idle, no fifo_rd.
- Single byte 0xA5 with fifo_empty=0 for one pop:
  - fifo_rd high for exactly 1 cycle.
  - txd sequence in 4-cycle groups: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_done pulses in cycle 40 after the pop. busy is high for 40 cycles.
- Back-to-back bytes 0x00 then 0xFF present in the FIFO -> second fifo_rd occurs exactly 41 cycles after the first. Frames appear on txd with a single idle cycle between them.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0x3C -> txd=1 and state=IDLE at the next edge. No tx_done pulse. After release, the next FIFO byte is sent as a complete frame.
- Parity (FIFO_UART_TX_PARITY_EN defined):
  - Byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0.
  - Frame is 44 cycles and tx_done pulses in cycle 44.
- Empty stall: FIFO becomes empty after one byte -> after tx_done, txd stays 1 and fifo_rd stays 0 until fifo_empty drops. Transmission resumes on the first cycle that fifo_empty=0.
